mem_port_sequencer: RTL and testbench

Arbiter and sequencer for the single-port 16-bit data memory shared by the fetch stage and the memory stage. It grants the port to the memory stage first, splits 32-bit PC push/pop (CALL/RET/INT) into two back-to-back 16-bit accesses, and produces stall/handshake signals to both requesters. It sits between the pipeline stages and the memory array. The SP arithmetic stays outside this block; it only consumes a final address.

---
 rtl/mem_port_sequencer_if.sv | 41 ++++
 rtl/mem_port_sequencer.sv | 148 ++++++++++++++
 tb/tb_mem_port_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_sequencer_if.sv
// mem_port_sequencer_if: fetch/memory-stage request bus plus the shared
// single-port memory interface; slave is the sequencer, master the outside.
interface mem_port_sequencer_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
);
   logic                i_if_req_unused_guard;
   logic                if_req;
   logic [15:0]         if_addr;
   logic                if_gnt;
   logic                if_valid;
   logic [DATA_W-1:0]   if_rdata;
   logic                ms_req;
   logic                ms_we;
   logic                ms_dbl;
   logic [15:0]         ms_addr;
   logic [2*DATA_W-1:0] ms_wdata;
   logic [2*DATA_W-1:0] ms_rdata;
   logic                ms_done;
   logic                stall_ms;
   logic                mem_en;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W-1:0]   mem_rdata;
   logic                addr_err;

   modport slave (
      input  if_req, if_addr, ms_req, ms_we, ms_dbl, ms_addr, ms_wdata,
      input  mem_rdata,
      output if_gnt, if_valid, if_rdata, ms_rdata, ms_done, stall_ms,
      output mem_en, mem_we, mem_addr, mem_wdata, addr_err
   );

   modport master (
      output if_req, if_addr, ms_req, ms_we, ms_dbl, ms_addr, ms_wdata,
      output mem_rdata,
      input  if_gnt, if_valid, if_rdata, ms_rdata, ms_done, stall_ms,
      input  mem_en, mem_we, mem_addr, mem_wdata, addr_err
   );
endinterface

// File: rtl/mem_port_sequencer.sv
// mem_port_sequencer: memory-stage-first arbiter for the shared data port,
// splitting 32-bit ops into two words. MEM_PORT_BOUNDS_EN adds range checks.
module mem_port_sequencer #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
) (
   input logic                 clk,
   input logic                 rst,
   mem_port_sequencer_if.slave bus
);
`ifdef MEM_PORT_BOUNDS_EN
   localparam int CW = 17;
`else
   localparam int CW = ADDR_W;
`endif

   typedef enum logic [1:0] {IDLE, MS_HI, MS_FIN} state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_we;
   logic              r_dbl;
   logic [CW-1:0]     r_addr;
   logic [DATA_W-1:0] r_wdata_hi;
   logic [2*DATA_W-1:0] r_rdata;
   logic              r_done;
   logic              r_if_valid;
   logic              r_if_zero;
   logic              r_ms_zero;

   logic              w_issue;
   logic              w_we;
   logic              w_gnt;
   logic              w_accept;
   logic              w_oob;
   logic              w_en;
   logic [CW-1:0]     w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic [DATA_W-1:0] w_rword;

`ifdef MEM_PORT_BOUNDS_EN
   logic r_err;
   assign w_oob        = |w_addr[CW-1:ADDR_W];
   assign bus.addr_err = r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_err <= 1'b0;
      else if (w_issue && w_oob)
         r_err <= 1'b1;
   end
`else
   assign w_oob        = 1'b0;
   assign bus.addr_err = 1'b0;
`endif

   always_comb begin
      w_next   = r_state;
      w_issue  = 1'b0;
      w_we     = 1'b0;
      w_gnt    = 1'b0;
      w_accept = 1'b0;
      w_addr   = '0;
      w_wdata  = '0;
      unique case (r_state)
         IDLE: begin
            if (bus.ms_req) begin
               w_accept = 1'b1;
               w_issue  = 1'b1;
               w_we     = bus.ms_we;
               w_addr   = CW'(bus.ms_addr);
               w_wdata  = bus.ms_wdata[DATA_W-1:0];
               w_next   = bus.ms_dbl ? MS_HI : MS_FIN;
            end else if (bus.if_req) begin
               w_gnt   = 1'b1;
               w_issue = 1'b1;
               w_addr  = CW'(bus.if_addr);
            end
         end
         MS_HI: begin
            w_issue = 1'b1;
            w_we    = r_we;
            w_addr  = r_addr + CW'(1);
            w_wdata = r_wdata_hi;
            w_next  = MS_FIN;
         end
         MS_FIN: begin
            // port is free while the stage consumes ms_done
            w_next = IDLE;
            if (bus.if_req) begin
               w_gnt   = 1'b1;
               w_issue = 1'b1;
               w_addr  = CW'(bus.if_addr);
            end
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_en          = w_issue & ~w_oob & ~rst;
   assign w_rword       = r_ms_zero ? '0 : bus.mem_rdata;
   assign bus.mem_en    = w_en;
   assign bus.mem_we    = w_en & w_we;
   assign bus.mem_addr  = w_addr[ADDR_W-1:0];
   assign bus.mem_wdata = w_wdata;
   assign bus.if_gnt    = w_gnt & ~rst;
   assign bus.if_valid  = r_if_valid;
   assign bus.if_rdata  = (r_if_valid && !r_if_zero) ? bus.mem_rdata : '0;
   assign bus.ms_rdata  = r_rdata;
   assign bus.ms_done   = r_done;
   assign bus.stall_ms  = bus.ms_req & ~r_done & ~rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_we       <= 1'b0;
         r_dbl      <= 1'b0;
         r_addr     <= '0;
         r_wdata_hi <= '0;
         r_rdata    <= '0;
         r_done     <= 1'b0;
         r_if_valid <= 1'b0;
         r_if_zero  <= 1'b0;
         r_ms_zero  <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_done     <= (w_next == MS_FIN);
         r_if_valid <= w_gnt;
         r_if_zero  <= w_gnt & w_oob;
         if (w_accept) begin
            r_we       <= bus.ms_we;
            r_dbl      <= bus.ms_dbl;
            r_addr     <= CW'(bus.ms_addr);
            r_wdata_hi <= bus.ms_wdata[2*DATA_W-1:DATA_W];
         end
         if (w_issue && !w_gnt)
            r_ms_zero <= w_oob;
         if (!r_we && r_state == MS_HI)
            r_rdata[DATA_W-1:0] <= w_rword;
         if (!r_we && r_state == MS_FIN) begin
            if (r_dbl)
               r_rdata[2*DATA_W-1:DATA_W] <= w_rword;
            else
               r_rdata <= {{DATA_W{1'b0}}, w_rword};
         end
      end
   end
endmodule

// File: tb/tb_mem_port_sequencer.sv
// tb_mem_port_sequencer: directed plus random ops against a transaction-level
// model of port timing and a shadow memory image.
module tb_mem_port_sequencer;
   localparam int AW    = 12;
   localparam int DW    = 16;
   localparam int DEPTH = 4096;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_port_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_port_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [15:0] mem     [DEPTH];
   logic [15:0] ref_mem [DEPTH];

   int          n_vec = 0;
   int          n_err = 0;
   bit          p_rd;
   bit          p_if;
   logic [31:0] p_rdata;
   logic [15:0] p_ifdata;
   bit          exp_err;

   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we)
            mem[bus.mem_addr] <= bus.mem_wdata;
         else
            bus.mem_rdata <= mem[bus.mem_addr];
      end
   end

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [16:0] waddr(logic [15:0] a, int k);
      return {1'b0, a} + 17'(k);
   endfunction

   function automatic bit in_rng(logic [16:0] a);
`ifdef MEM_PORT_BOUNDS_EN
      return int'(a) < DEPTH;
`else
      return (a == a);
`endif
   endfunction

   function automatic int idx(logic [16:0] a);
      return int'(a) % DEPTH;
   endfunction

   function automatic logic [15:0] ref_rd(logic [16:0] a);
      return in_rng(a) ? ref_mem[idx(a)] : 16'h0000;
   endfunction

   task automatic check_pending();
      if (p_rd) check("ms_rdata", bus.ms_rdata, p_rdata);
      check("if_valid", bus.if_valid, p_if);
      if (p_if) check("if_rdata", bus.if_rdata, p_ifdata);
      p_rd = 1'b0;
      p_if = 1'b0;
   endtask

   task automatic slot_check(string tag, logic [16:0] a, bit we, logic [15:0] wd);
      check({tag, "_mem_en"}, bus.mem_en, in_rng(a));
      check({tag, "_mem_we"}, bus.mem_we, we & in_rng(a));
      if (in_rng(a)) begin
         check({tag, "_mem_addr"}, bus.mem_addr, idx(a));
         if (we) begin
            check({tag, "_mem_wdata"}, bus.mem_wdata, wd);
            ref_mem[idx(a)] = wd;
         end
      end else begin
         exp_err = 1'b1;
      end
   endtask

   task automatic ms_op(bit we, bit dbl, logic [15:0] addr, logic [31:0] wd,
                        bit fe, logic [15:0] fa, bit drop);
      int          len;
      logic [31:0] exp_rd;
      len = dbl ? 2 : 1;
      @(posedge clk); #1;
      bus.ms_req   = 1'b1;
      bus.ms_we    = we;
      bus.ms_dbl   = dbl;
      bus.ms_addr  = addr;
      bus.ms_wdata = wd;
      bus.if_req   = fe;
      bus.if_addr  = fa;
      exp_rd = {dbl ? ref_rd(waddr(addr, 1)) : 16'h0000, ref_rd(waddr(addr, 0))};
      @(negedge clk);
      check_pending();
      slot_check("c0", waddr(addr, 0), we, wd[15:0]);
      check("c0_if_gnt", bus.if_gnt, 1'b0);
      check("c0_stall", bus.stall_ms, 1'b1);
      check("c0_done", bus.ms_done, 1'b0);
      for (int c = 1; c <= len; c++) begin
         @(posedge clk); #1;
         if (drop) bus.ms_req = 1'b0;
         @(negedge clk);
         check_pending();
         if (c < len) begin
            slot_check("hi", waddr(addr, 1), we, wd[31:16]);
            check("hi_if_gnt", bus.if_gnt, 1'b0);
            check("hi_done", bus.ms_done, 1'b0);
            check("hi_stall", bus.stall_ms, !drop);
         end else begin
            check("fin_done", bus.ms_done, 1'b1);
            check("fin_stall", bus.stall_ms, 1'b0);
            check("fin_if_gnt", bus.if_gnt, fe);
            if (fe) slot_check("fin", {1'b0, fa}, 1'b0, 16'h0);
            else check("fin_mem_en", bus.mem_en, 1'b0);
         end
      end
      p_rd     = !we;
      p_rdata  = exp_rd;
      p_if     = fe;
      p_ifdata = ref_rd({1'b0, fa});
   endtask

   task automatic idle_cyc();
      @(posedge clk); #1;
      bus.ms_req = 1'b0;
      bus.if_req = 1'b0;
      @(negedge clk);
      check_pending();
      check("idle_done", bus.ms_done, 1'b0);
      check("idle_mem_en", bus.mem_en, 1'b0);
      check("idle_stall", bus.stall_ms, 1'b0);
   endtask

   task automatic fetch_only(logic [15:0] fa);
      @(posedge clk); #1;
      bus.ms_req  = 1'b0;
      bus.if_req  = 1'b1;
      bus.if_addr = fa;
      @(negedge clk);
      check_pending();
      check("fo_if_gnt", bus.if_gnt, 1'b1);
      slot_check("fo", {1'b0, fa}, 1'b0, 16'h0);
      p_if     = 1'b1;
      p_ifdata = ref_rd({1'b0, fa});
   endtask

   initial begin
      logic [15:0] a;
      logic [15:0] f;
      int          sel;
      int          nbad;
      bus.if_req   = 1'b0;
      bus.if_addr  = '0;
      bus.ms_req   = 1'b0;
      bus.ms_we    = 1'b0;
      bus.ms_dbl   = 1'b0;
      bus.ms_addr  = '0;
      bus.ms_wdata = '0;
      p_rd    = 1'b0;
      p_if    = 1'b0;
      exp_err = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]     = 16'($urandom);
         ref_mem[i] = mem[i];
      end

      // requests during reset must not reach the port
      bus.ms_req = 1'b1;
      bus.if_req = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_mem_en", bus.mem_en, 1'b0);
      check("rst_if_gnt", bus.if_gnt, 1'b0);
      check("rst_done", bus.ms_done, 1'b0);
      check("rst_if_valid", bus.if_valid, 1'b0);
      check("rst_ms_rdata", bus.ms_rdata, 32'h0);
      check("rst_addr_err", bus.addr_err, 1'b0);
      bus.ms_req = 1'b0;
      bus.if_req = 1'b0;
      rst = 1'b0;

      mem[16'h0010]     = 16'hBEEF;
      ref_mem[16'h0010] = 16'hBEEF;
      ms_op(1'b0, 1'b0, 16'h0010, 32'h0, 1'b0, 16'h0, 1'b0);
      idle_cyc();

      ms_op(1'b1, 1'b1, 16'h0FFE, 32'h12345678, 1'b0, 16'h0, 1'b0);
      idle_cyc();
      check("dw_lo_word", mem[12'hFFE], 16'h5678);
      check("dw_hi_word", mem[12'hFFF], 16'h1234);

      mem[16'h0004]     = 16'hA5C3;
      ref_mem[16'h0004] = 16'hA5C3;
      ms_op(1'b0, 1'b0, 16'h0030, 32'h0, 1'b1, 16'h0004, 1'b0);
      idle_cyc();

      ms_op(1'b0, 1'b1, 16'h0FFF, 32'h0, 1'b0, 16'h0, 1'b0);
      idle_cyc();
      check("wrap_addr_err", bus.addr_err, exp_err);

      // reset in the high-word slot of a double write
      @(posedge clk); #1;
      bus.ms_req   = 1'b1;
      bus.ms_we    = 1'b1;
      bus.ms_dbl   = 1'b1;
      bus.ms_addr  = 16'h0020;
      bus.ms_wdata = 32'hCAFEF00D;
      @(negedge clk);
      check("mr_c0_mem_en", bus.mem_en, 1'b1);
      ref_mem[16'h0020] = 16'hF00D;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("mr_mem_en", bus.mem_en, 1'b0);
      check("mr_done", bus.ms_done, 1'b0);
      check("mr_stall", bus.stall_ms, 1'b0);
      check("mr_if_valid", bus.if_valid, 1'b0);
      check("mr_ms_rdata", bus.ms_rdata, 32'h0);
      check("mr_addr_err", bus.addr_err, 1'b0);
      exp_err = 1'b0;
      @(negedge clk);
      bus.ms_req = 1'b0;
      rst = 1'b0;
      check("mr_word0", mem[16'h0020], 16'hF00D);
      check("mr_word1_kept", mem[16'h0021], ref_mem[16'h0021]);
      ms_op(1'b0, 1'b1, 16'h0020, 32'h0, 1'b0, 16'h0, 1'b0);
      idle_cyc();

      // ms_req held across ms_done: each op accepted exactly once
      ms_op(1'b0, 1'b0, 16'h0100, 32'h0, 1'b0, 16'h0, 1'b0);
      ms_op(1'b0, 1'b0, 16'h0101, 32'h0, 1'b0, 16'h0, 1'b0);
      ms_op(1'b1, 1'b1, 16'h0200, 32'h89ABCDEF, 1'b1, 16'h0201, 1'b0);
      idle_cyc();
      fetch_only(16'h0123);
      idle_cyc();

      for (int n = 0; n < 300; n++) begin
         sel = $urandom_range(0, 9);
         a = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                         : 16'($urandom_range(0, DEPTH - 1));
         f = ($urandom_range(0, 5) == 0) ? 16'($urandom)
                                         : 16'($urandom_range(0, DEPTH - 1));
         if (sel < 2)
            fetch_only(f);
         else if (sel == 2)
            idle_cyc();
         else
            ms_op(1'($urandom), 1'($urandom), a, $urandom, 1'($urandom), f,
                  $urandom_range(0, 7) == 0);
      end
      idle_cyc();
      idle_cyc();

      nbad = 0;
      for (int i = 0; i < DEPTH; i++)
         if (mem[i] !== ref_mem[i]) nbad++;
      check("mem_image_bad_words", nbad, 0);
      check("final_addr_err", bus.addr_err, exp_err);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
